// File: rtl/vga_timing_pkg.sv
// VGA timing package: 640x480@60 defaults, derived totals and sync windows,
// counter width and the blanking-phase type shared by the sync generator.
package vga_timing_pkg;

  localparam int unsigned CntW = 10;

  // 640x480@60 defaults
  localparam int unsigned DefHVisible = 640;
  localparam int unsigned DefHFront   = 16;
  localparam int unsigned DefHSync    = 96;
  localparam int unsigned DefHBack    = 48;
  localparam int unsigned DefVVisible = 480;
  localparam int unsigned DefVFront   = 10;
  localparam int unsigned DefVSync    = 2;
  localparam int unsigned DefVBack    = 33;

  localparam int unsigned DefHTotal     = DefHVisible + DefHFront + DefHSync + DefHBack;
  localparam int unsigned DefVTotal     = DefVVisible + DefVFront + DefVSync + DefVBack;
  localparam int unsigned DefHSyncStart = DefHVisible + DefHFront;
  localparam int unsigned DefHSyncEnd   = DefHSyncStart + DefHSync;
  localparam int unsigned DefVSyncStart = DefVVisible + DefVFront;
  localparam int unsigned DefVSyncEnd   = DefVSyncStart + DefVSync;

  typedef enum logic [1:0] {
    PhActive,
    PhFront,
    PhSync,
    PhBack
  } phase_e;

  // Phase a counter position falls in; sync window is [sync_start, sync_end).
  function automatic phase_e phase_of(input logic [CntW-1:0] pos,
                                      input logic [CntW-1:0] visible,
                                      input logic [CntW-1:0] sync_start,
                                      input logic [CntW-1:0] sync_end);
    phase_e ph;
    ph = PhBack;
    if (pos < visible) begin
      ph = PhActive;
    end else if (pos < sync_start) begin
      ph = PhFront;
    end else if (pos < sync_end) begin
      ph = PhSync;
    end
    return ph;
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-enable divider: counts 0..CLK_DIV-1 and strobes once per wrap.
// tick_en is the combinational advance strobe used by the counters in the
// same clk; pixelTick is its registered copy for the outside world.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick_en,
  output logic pixelTick
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            pixel_tick_q;

  // Next divider value; wrap strobe when leaving the last count.
  always_comb begin
    tick_en = (div_q == DivLast);
    div_d   = tick_en ? '0 : div_q + 1'b1;
  end

  // Divider and registered strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q        <= '0;
      pixel_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      pixel_tick_q <= tick_en;
    end
  end

  assign pixelTick = pixel_tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters, blanking phases, registered sync
// decode and a SYNC_DELAY-stage delay line on hsync/vsync so sync lines up
// with the renderer's registered rgb. Optional frame counter output under
// VGA_FRAME_COUNT_EN.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned H_VISIBLE  = DefHVisible,
  parameter int unsigned H_FRONT    = DefHFront,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BACK     = DefHBack,
  parameter int unsigned V_VISIBLE  = DefVVisible,
  parameter int unsigned V_FRONT    = DefVFront,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BACK     = DefVBack,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [CntW-1:0] x,
  output logic [CntW-1:0] y,
  output logic            videoOn,
  output logic            hsync,
  output logic            vsync,
  output logic            pixelTick,
  output logic            lineStart,
`ifdef VGA_FRAME_COUNT_EN
  output logic [15:0]     frameCount,
`endif
  output logic            frameStart
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CntW-1:0] HVis       = CntW'(H_VISIBLE);
  localparam logic [CntW-1:0] HSyncStart = CntW'(H_VISIBLE + H_FRONT);
  localparam logic [CntW-1:0] HSyncEnd   = CntW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CntW-1:0] HLast      = CntW'(HTotal - 1);
  localparam logic [CntW-1:0] VVis       = CntW'(V_VISIBLE);
  localparam logic [CntW-1:0] VSyncStart = CntW'(V_VISIBLE + V_FRONT);
  localparam logic [CntW-1:0] VSyncEnd   = CntW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CntW-1:0] VLast      = CntW'(VTotal - 1);

  if (HTotal > 1024) begin : gen_err_htotal
    $error("vga_sync_gen: H total exceeds 10-bit counter");
  end
  if (VTotal > 1024) begin : gen_err_vtotal
    $error("vga_sync_gen: V total exceeds 10-bit counter");
  end
  if (CLK_DIV < 1) begin : gen_err_clk_div
    $error("vga_sync_gen: CLK_DIV must be at least 1");
  end
  if (SYNC_DELAY > 4) begin : gen_err_sync_delay
    $error("vga_sync_gen: SYNC_DELAY must be 0..4");
  end

  logic            tick;
  logic [CntW-1:0] x_q, x_d, y_q, y_d;
  logic            line_wrap, frame_wrap;
  phase_e          h_phase_q, h_phase_d, v_phase_q, v_phase_d;
  logic            video_on_q, line_start_q, frame_start_q;
  logic            hsync_raw_q, vsync_raw_q;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick_en  (tick),
    .pixelTick(pixelTick)
  );

  // Counter advance: x every tick, y on x wrap, both wrap at frame end.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    line_wrap  = 1'b0;
    frame_wrap = 1'b0;
    if (tick) begin
      if (x_q == HLast) begin
        x_d       = '0;
        line_wrap = 1'b1;
        if (y_q == VLast) begin
          y_d        = '0;
          frame_wrap = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Phase FSMs: horizontal steps per tick, vertical steps per line wrap.
  always_comb begin
    h_phase_d = h_phase_q;
    v_phase_d = v_phase_q;
    if (tick) begin
      h_phase_d = phase_of(x_d, HVis, HSyncStart, HSyncEnd);
    end
    if (line_wrap) begin
      v_phase_d = phase_of(y_d, VVis, VSyncStart, VSyncEnd);
    end
  end

  // Counters, phases, strobes and raw sync, all aligned to the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      h_phase_q     <= PhActive;
      v_phase_q     <= PhActive;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_raw_q   <= 1'b1;
      vsync_raw_q   <= 1'b1;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      h_phase_q     <= h_phase_d;
      v_phase_q     <= v_phase_d;
      line_start_q  <= line_wrap;
      frame_start_q <= frame_wrap;
      if (tick) begin
        video_on_q  <= (h_phase_d == PhActive) && (v_phase_d == PhActive);
        hsync_raw_q <= (h_phase_d != PhSync);
        vsync_raw_q <= (v_phase_d != PhSync);
      end
    end
  end

  if (SYNC_DELAY == 0) begin : gen_no_delay
    assign hsync = hsync_raw_q;
    assign vsync = vsync_raw_q;
  end else begin : gen_delay
    logic [SYNC_DELAY-1:0] hsync_dly_q, hsync_dly_d, vsync_dly_q, vsync_dly_d;

    // Shift raw sync one stage per clk, independent of the pixel tick.
    always_comb begin
      hsync_dly_d    = hsync_dly_q << 1;
      vsync_dly_d    = vsync_dly_q << 1;
      hsync_dly_d[0] = hsync_raw_q;
      vsync_dly_d[0] = vsync_raw_q;
    end

    // Delay stages reset high so no stale pulse escapes after reset.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hsync_dly_q <= '1;
        vsync_dly_q <= '1;
      end else begin
        hsync_dly_q <= hsync_dly_d;
        vsync_dly_q <= vsync_dly_d;
      end
    end

    assign hsync = hsync_dly_q[SYNC_DELAY-1];
    assign vsync = vsync_dly_q[SYNC_DELAY-1];
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_q;

  // Count frame starts; updates the clk after each frameStart strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
    end else if (frame_start_q) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign frameCount = frame_count_q;
`endif

  assign x          = x_q;
  assign y          = y_q;
  assign videoOn    = video_on_q;
  assign lineStart  = line_start_q;
  assign frameStart = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: four instances (default timing, and a shrunken
// timing with several CLK_DIV/SYNC_DELAY mixes) checked every cycle against a
// closed-form model computed from the number of clocks since reset release.
module tb_vga_sync_gen;

  // Shrunken timing: 32 ticks/line, 17 lines/frame.
  localparam int unsigned SHv = 20, SHf = 3, SHs = 5, SHb = 4;
  localparam int unsigned SVv = 10, SVf = 2, SVs = 2, SVb = 3;
  localparam logic [25:0] RstObs = 26'h18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned n = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // Rising edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  logic [9:0] def_x, def_y, sm_x, sm_y, fast_x, fast_y, d4_x, d4_y;
  logic def_vo, def_hs, def_vs, def_pt, def_ls, def_fs;
  logic sm_vo, sm_hs, sm_vs, sm_pt, sm_ls, sm_fs;
  logic fast_vo, fast_hs, fast_vs, fast_pt, fast_ls, fast_fs;
  logic d4_vo, d4_hs, d4_vs, d4_pt, d4_ls, d4_fs;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] def_fc, sm_fc, fast_fc, d4_fc;
`endif

  vga_sync_gen dut_def (
    .clk(clk), .reset_n(rst_n), .x(def_x), .y(def_y), .videoOn(def_vo),
    .hsync(def_hs), .vsync(def_vs), .pixelTick(def_pt), .lineStart(def_ls),
`ifdef VGA_FRAME_COUNT_EN
    .frameCount(def_fc),
`endif
    .frameStart(def_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(4), .SYNC_DELAY(1), .H_VISIBLE(SHv), .H_FRONT(SHf), .H_SYNC(SHs),
    .H_BACK(SHb), .V_VISIBLE(SVv), .V_FRONT(SVf), .V_SYNC(SVs), .V_BACK(SVb)
  ) dut_sm (
    .clk(clk), .reset_n(rst_n), .x(sm_x), .y(sm_y), .videoOn(sm_vo),
    .hsync(sm_hs), .vsync(sm_vs), .pixelTick(sm_pt), .lineStart(sm_ls),
`ifdef VGA_FRAME_COUNT_EN
    .frameCount(sm_fc),
`endif
    .frameStart(sm_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .SYNC_DELAY(0), .H_VISIBLE(SHv), .H_FRONT(SHf), .H_SYNC(SHs),
    .H_BACK(SHb), .V_VISIBLE(SVv), .V_FRONT(SVf), .V_SYNC(SVs), .V_BACK(SVb)
  ) dut_fast (
    .clk(clk), .reset_n(rst_n), .x(fast_x), .y(fast_y), .videoOn(fast_vo),
    .hsync(fast_hs), .vsync(fast_vs), .pixelTick(fast_pt), .lineStart(fast_ls),
`ifdef VGA_FRAME_COUNT_EN
    .frameCount(fast_fc),
`endif
    .frameStart(fast_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .SYNC_DELAY(4), .H_VISIBLE(SHv), .H_FRONT(SHf), .H_SYNC(SHs),
    .H_BACK(SHb), .V_VISIBLE(SVv), .V_FRONT(SVf), .V_SYNC(SVs), .V_BACK(SVb)
  ) dut_d4 (
    .clk(clk), .reset_n(rst_n), .x(d4_x), .y(d4_y), .videoOn(d4_vo),
    .hsync(d4_hs), .vsync(d4_vs), .pixelTick(d4_pt), .lineStart(d4_ls),
`ifdef VGA_FRAME_COUNT_EN
    .frameCount(d4_fc),
`endif
    .frameStart(d4_fs)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [25:0] pack(input logic [9:0] px, input logic [9:0] py,
                                       input logic vo, input logic hs, input logic vs,
                                       input logic pt, input logic ls, input logic fs);
    return {px, py, vo, hs, vs, pt, ls, fs};
  endfunction

  // Expected outputs after cyc clocks since release: tick count = cyc / cdiv,
  // raster position = ticks mod frame size, sync = raw sync sd clocks earlier.
  function automatic logic [25:0] model(input int unsigned cyc, input int unsigned cdiv,
                                        input int unsigned sd, input int unsigned hv,
                                        input int unsigned hf, input int unsigned hs,
                                        input int unsigned hb, input int unsigned vv,
                                        input int unsigned vf, input int unsigned vs,
                                        input int unsigned vb);
    int unsigned ht, vt, ticks, pos, px, py, sx, sy;
    logic pt, vo, ls, fs, hsy, vsy;
    ht    = hv + hf + hs + hb;
    vt    = vv + vf + vs + vb;
    ticks = cyc / cdiv;
    pos   = ticks % (ht * vt);
    px    = pos % ht;
    py    = pos / ht;
    pt    = (cyc > 0) && (cyc % cdiv == 0);
    vo    = (ticks > 0) && (px < hv) && (py < vv);
    ls    = pt && (px == 0);
    fs    = pt && (pos == 0);
    hsy   = 1'b1;
    vsy   = 1'b1;
    if (cyc >= sd) begin
      pos = ((cyc - sd) / cdiv) % (ht * vt);
      sx  = pos % ht;
      sy  = pos / ht;
      hsy = !((sx >= hv + hf) && (sx < hv + hf + hs));
      vsy = !((sy >= vv + vf) && (sy < vv + vf + vs));
    end
    return {10'(px), 10'(py), vo, hsy, vsy, pt, ls, fs};
  endfunction

  // Tracker state for interval/width measurements.
  int unsigned def_ls_n, def_x656_n, def_hsf_n, sm_fs_n, sm_vsf_n, sm_ymax;
  logic def_ls_v, def_x656_v, def_hsf_v, sm_fs_v, sm_vsf_v;
  logic def_hs_prev, sm_vs_prev;
  logic [9:0] def_x_prev;

  initial begin
    sm_ymax = 0;
    forever begin
      @(negedge clk);
      check_val("def_state", pack(def_x, def_y, def_vo, def_hs, def_vs, def_pt, def_ls, def_fs),
                model(n, 4, 1, 640, 16, 96, 48, 480, 10, 2, 33));
      check_val("sm_state", pack(sm_x, sm_y, sm_vo, sm_hs, sm_vs, sm_pt, sm_ls, sm_fs),
                model(n, 4, 1, SHv, SHf, SHs, SHb, SVv, SVf, SVs, SVb));
      check_val("fast_state", pack(fast_x, fast_y, fast_vo, fast_hs, fast_vs, fast_pt, fast_ls,
                fast_fs), model(n, 1, 0, SHv, SHf, SHs, SHb, SVv, SVf, SVs, SVb));
      check_val("d4_state", pack(d4_x, d4_y, d4_vo, d4_hs, d4_vs, d4_pt, d4_ls, d4_fs),
                model(n, 3, 4, SHv, SHf, SHs, SHb, SVv, SVf, SVs, SVb));
`ifdef VGA_FRAME_COUNT_EN
      check_val("sm_fcount", sm_fc, (n == 0) ? 32'd0 : 32'(16'((n - 1) / 2176)));
      check_val("d4_fcount", d4_fc, (n == 0) ? 32'd0 : 32'(16'((n - 1) / 1632)));
`endif
      if (!rst_n) begin
        def_ls_v = 0; def_x656_v = 0; def_hsf_v = 0; sm_fs_v = 0; sm_vsf_v = 0;
        def_hs_prev = 1; sm_vs_prev = 1; def_x_prev = '0;
      end else begin
        if (def_ls) begin
          if (def_ls_v) check_val("def_line_period", n - def_ls_n, 3200);
          def_ls_v = 1; def_ls_n = n;
        end
        if (def_x == 10'd656 && def_x_prev != 10'd656) begin
          def_x656_v = 1; def_x656_n = n;
        end
        if (!def_hs && def_hs_prev) begin
          if (def_x656_v) check_val("def_hs_lag", n - def_x656_n, 1);
          def_hsf_v = 1; def_hsf_n = n;
        end
        if (def_hs && !def_hs_prev && def_hsf_v) check_val("def_hs_width", n - def_hsf_n, 384);
        if (sm_fs) begin
          check_val("sm_fs_with_ls", sm_ls, 1);
          if (sm_fs_v) check_val("sm_frame_period", n - sm_fs_n, 2176);
          sm_fs_v = 1; sm_fs_n = n;
        end
        if (!sm_vs && sm_vs_prev) begin
          sm_vsf_v = 1; sm_vsf_n = n;
        end
        if (sm_vs && !sm_vs_prev && sm_vsf_v) check_val("sm_vs_width", n - sm_vsf_n, 256);
        if (32'(sm_y) > sm_ymax) sm_ymax = 32'(sm_y);
        check_val("fast_hs_align", fast_hs, !(fast_x >= 10'd23 && fast_x < 10'd28));
        if (n >= 1) check_val("fast_tick_high", fast_pt, 1);
        def_hs_prev = def_hs; sm_vs_prev = sm_vs; def_x_prev = def_x;
      end
    end
  end

  initial begin
    int unsigned waited;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_def", pack(def_x, def_y, def_vo, def_hs, def_vs, def_pt, def_ls, def_fs), RstObs);
    check_val("rst_d4", pack(d4_x, d4_y, d4_vo, d4_hs, d4_vs, d4_pt, d4_ls, d4_fs), RstObs);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check_val("def_first_tick", def_pt, (i == 4) ? 32'd1 : 32'd0);
    end
    check_val("def_x_after_tick", def_x, 1);
    check_val("def_video_on", def_vo, 1);
    repeat (7000) @(negedge clk);
`ifdef VGA_FRAME_COUNT_EN
    check_val("sm_fc_3", sm_fc, 3);
`endif

    // Reset in the middle of an hsync and vsync pulse on the small config.
    waited = 0;
    while (!(sm_x == 10'd25 && sm_y == 10'd12) && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check_val("sm_reach_sync", (waited < 5000) ? 32'd1 : 32'd0, 1);
    check_val("sm_in_sync", {sm_hs, sm_vs}, 2'b00);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_sync", {sm_hs, sm_vs, def_hs, def_vs, fast_hs, fast_vs, d4_hs, d4_vs},
              8'hff);
    check_val("async_rst_xy", {sm_x, sm_y, def_x, def_y}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2500) @(negedge clk);

    // Random run lengths and reset points.
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(1500, 50)) @(negedge clk);
      @(posedge clk);
      #($urandom_range(3, 1)) rst_n = 1'b0;
      #1;
      check_val("rnd_rst_x", {def_x, sm_x, fast_x}, 0);
      check_val("rnd_rst_y", {def_y, sm_y, d4_y, d4_x}, 0);
      check_val("rnd_rst_sync", {def_hs, def_vs, d4_hs, d4_vs, sm_hs, sm_vs}, 6'h3f);
      repeat ($urandom_range(4, 1)) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (3000) @(negedge clk);
    check_val("sm_y_max", sm_ymax, 16);

`ifdef VGA_FRAME_COUNT_EN
    force dut_fast.frame_count_q = 16'hffff;
    @(negedge clk);
    release dut_fast.frame_count_q;
    waited = 0;
    while (!fast_fs && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check_val("fast_fc_wrap", fast_fc, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing source that drives the grid renderer's pixel interface: generates pixel coordinates `x`/`y`, `videoOn`, and the VGA `hsync`/`vsync` pins for 640x480@60 Hz.
- Runs from the 100 MHz system clock, with an internal pixel-enable divider (default /4, giving 25 MHz).
- The renderer registers `rgb` one clk after seeing `x`/`y`, so this block delays `hsync`/`vsync` to keep sync aligned with pixel data at the connector.
- Also emits line-start and frame-start strobes for game logic that must update cell colours only during blanking.

Parameters:
- CLK_DIV, 4, system clocks per pixel (min 1; 1 = tick every clk)
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_DELAY, 1, extra clk stages applied to `hsync`/`vsync` only (0..4)

Ports:
- clk  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous, active-low reset
- x  out  10  horizontal pixel count, 0..H_TOTAL-1
- y  out  10  vertical line count, 0..V_TOTAL-1
- videoOn  out  1  high while x < H_VISIBLE and y < V_VISIBLE
- hsync  out  1  horizontal sync, active low, delayed by SYNC_DELAY clk
- vsync  out  1  vertical sync, active low, delayed by SYNC_DELAY clk
- pixelTick  out  1  one-clk strobe every CLK_DIV clocks
- lineStart  out  1  one-clk strobe on the tick where x wraps to 0
- frameStart  out  1  one-clk strobe on the tick where (x,y) becomes (0,0)

Behaviour:
- Clocking and reset
  - One clock (`clk`). Reset is asynchronous and active-low (`reset_n`). All outputs are registered.
  - Reset values:
    - x = 0, y = 0
    - videoOn = 0
    - hsync = 1, vsync = 1, including every SYNC_DELAY stage
    - pixelTick = 0, lineStart = 0, frameStart = 0
    - divider = 0
- Timing totals
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK = 800.
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK = 525.
- Pixel divider
  - Counter runs 0..CLK_DIV-1 and wraps to 0.
  - pixelTick is registered high for the clk in which the divider moves from CLK_DIV-1 to 0. The first tick follows CLK_DIV clocks after reset release.
- Counter advance (only on a tick)
  - x increments each tick.
  - When x = H_TOTAL-1: x wraps to 0, lineStart pulses, and y increments.
  - When y = V_TOTAL-1 at that same wrap: y wraps to 0 and frameStart also pulses.
  - lineStart and frameStart assert together at the frame wrap.
  - Between ticks, x, y and videoOn hold their values.
- Derived outputs
  - videoOn is registered from the next-state x/y, so it changes in the same cycle as x/y.
  - Raw hsync is low when H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - Raw vsync is low when V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - Raw syncs are registered alongside x/y, then pass through SYNC_DELAY clk stages (shift register clocked every clk, not gated by tick). SYNC_DELAY = 0 means sync aligns with x/y.
- Counter state machine, advancing per tick on x position: ACTIVE (x<640) -> FRONT -> SYNC -> BACK -> ACTIVE. Vertical uses the same phases on y, advanced on lineStart.
- Reset mid-frame: all counters and delay stages clear immediately. Sync pins go high asynchronously, with no partial pulse afterwards.
- Widths: counters are 10 bits.
  - Elaboration error if H_TOTAL > 1024, V_TOTAL > 1024, CLK_DIV < 1, or SYNC_DELAY > 4.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- When defined: adds output `frameCount` [15:0], reset 0, incremented on the clk after each frameStart, wrapping 65535 -> 0. Used for animation/blink timing.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 default constants (H_VISIBLE..V_BACK).
  - Derived H_TOTAL, V_TOTAL, sync start/end localparams.
  - Counter width constant (10).
- Natural sub-module: pixel_tick_gen (CLK_DIV divider producing pixelTick).
- Counters, sync decode and delay line stay in vga_sync_gen.

Test Plan:
- Reset release, CLK_DIV=4: first pixelTick at clk 4. x=1 after first tick. videoOn=1 while x<640, y<480.
- Run one line: lineStart exactly every 3200 clk.
  - hsync low for exactly 96 ticks (384 clk), starting 1 clk (SYNC_DELAY) after x becomes 656.
- Run full frame: frameStart period 1,680,000 clk, coincident with lineStart. vsync low for lines 490-491 only (6400 clk). y never exceeds 524.
- Assert reset_n low at x=700, y=491 (mid hsync and vsync): hsync=vsync=1 immediately, x=y=0. After release, the frame restarts cleanly.
- CLK_DIV=1, SYNC_DELAY=0: pixelTick constantly high. hsync low exactly when x in 656..751 with zero-cycle offset.
- With VGA_FRAME_COUNT_EN: frameCount reads 3 after 3 frameStart pulses. Forced wrap from 65535 reads 0.
